pipe_stall_ctrl: RTL and testbench
==================================

Name: pipe_stall_ctrl

Overview:
- Parametrised pipeline hazard and stall controller for the N-issue MIPS core.
- Generalises the single-issue stall logic to ISSUE_W lanes and configurable load-use bubble depth.
- Adds optional store→load ordering, outstanding-memory-request tracking, flush deferral across fetch stalls, and saturating performance counters.
- Sits beside the IF/ID, ID/EX and EX/MEM pipeline registers and drives their stall, bubble and flush controls.

Parameters:
- ISSUE_W, 2, number of issue lanes (1..4).
- LU_BUBBLES, 1, stall cycles inserted per load-use hazard (1..3).
- STORE_LOAD_EN, 1, 1 = stall a load in ID/EX behind a store in EX; 0 = never.
- MAX_OUT, 2, maximum outstanding data-memory requests (1..7).
- PERF_W, 32, performance counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- de_valid  in  ISSUE_W  decode-lane valid.
- de_rs  in  5*ISSUE_W  decode rs, lane i at [5i+4:5i].
- de_rt  in  5*ISSUE_W  decode rt, same packing.
- ex_valid  in  ISSUE_W  EX-lane valid.
- ex_mem_type  in  2*ISSUE_W  EX memory type (`MEM_LOAD`/`MEM_STOR` encodings from common.vh).
- ex_rt  in  5*ISSUE_W  EX load destination.
- id_ex_mem_type  in  2*ISSUE_W  memory type held in ID/EX.
- if_stall_i  in  1  fetch stall.
- ex_stall_i  in  1  multicycle execute stall.
- mem_stall_i  in  1  data memory stall.
- mem_req  in  1  data request accepted this cycle.
- data_ok  in  1  data response this cycle.
- flush  in  1  branch/exception flush request.
- perf_clr  in  1  synchronous clear of performance counters.
- if_id_stall_o  out  1  hold IF/ID.
- id_ex_stall_o  out  1  hold ID/EX.
- ex_mem_stall_o  out  1  hold EX/MEM.
- id_ex_bubble_o  out  1  load NOP into ID/EX.
- flush_o  out  1  applied flush.
- out_cnt_o  out  3  outstanding request count.
- stall_cnt_o  out  PERF_W  cycles with if_id_stall_o high.
- lu_cnt_o  out  PERF_W  load-use events.

Behaviour:
- Reset (rst=0, async): lu_cnt_q=0, flush_pend=0, out_cnt=0, both perf counters=0. All combinational outputs are 0 when all inputs are 0.
- frozen = if_stall_i | mem_stall_i.
- lu_hit: any EX lane j with ex_valid[j], type LOAD and ex_rt[j]!=0 whose ex_rt[j] equals de_rs[i] or de_rt[i] of any lane i with de_valid[i].
- lu_stall = lu_hit | (lu_cnt_q!=0).
- Bubble counter:
  - On lu_hit with lu_cnt_q==0, !frozen, !flush_o: load lu_cnt_q = LU_BUBBLES-1 and increment lu_cnt_o.
  - Otherwise decrement lu_cnt_q when nonzero and !frozen.
  - flush_o clears lu_cnt_q to 0.
- sl_stall = STORE_LOAD_EN & (any EX lane valid STORE) & (any id_ex lane LOAD).
- req_full = mem_req & (out_cnt==MAX_OUT) & !data_ok.
- out_cnt update:
  - +1 on mem_req only, -1 on data_ok only, unchanged on both.
  - Never underflows: data_ok at 0 is ignored.
  - Never exceeds MAX_OUT: a blocked request is not counted.
- Stall outputs:
  - if_id_stall_o = ex_stall_i | lu_stall | sl_stall | frozen | req_full.
  - id_ex_stall_o = frozen | req_full.
  - id_ex_bubble_o = (lu_stall | sl_stall) & !id_ex_stall_o & !ex_stall_i.
- Flush deferral:
  - flush with !if_stall_i → flush_o=1 the same cycle.
  - flush with if_stall_i → flush_pend=1, flush_o=0.
  - flush_o = (flush | flush_pend) & !if_stall_i. flush_pend clears the cycle flush_o fires.
  - A second flush while pending merges into the one pending flush.
- ex_mem_stall_o:
  - While flush or flush_pend: = if_stall_i.
  - Otherwise: = mem_stall_i & !data_ok.
- Perf counters:
  - stall_cnt_o += 1 each cycle if_id_stall_o=1.
  - Both counters saturate at all-ones.
  - perf_clr has priority over increment.
- No combinational path from outputs to inputs. All state is registered on clk rising edge.

Test Plan:
- ISSUE_W=2, LU_BUBBLES=2: EX lane1 LOAD ex_rt=8, decode lane0 de_rs=8 → if_id_stall_o=1 and id_ex_bubble_o=1 for 2 cycles; lu_cnt_o=1.
- Same hazard with ex_rt=0, or with de_valid=0 → no stall, lu_cnt_o stays 0.
- STORE_LOAD_EN=1, EX STORE and ID/EX LOAD → if_id_stall_o=1, bubble=1. Repeat with STORE_LOAD_EN=0 → 0.
- MAX_OUT=2: three mem_req in consecutive cycles, no data_ok → out_cnt_o=2, third cycle req_full raises id_ex_stall_o=1. Then data_ok together with mem_req → out_cnt_o stays 2, stall drops.
- flush pulse while if_stall_i=1 for 3 cycles → flush_o=0 then, ex_mem_stall_o=1; flush_o=1 for exactly one cycle when if_stall_i falls.
- Assert rst low mid load-use countdown with pending flush → lu_cnt_q, flush_pend, out_cnt and counters all 0 immediately. Then perf_clr with saturated stall_cnt_o → 0 next cycle.

Source files
------------

// File: rtl/pipe_stall_ctrl_if.sv
// Interface bundling the decode/EX/ID-EX hazard inputs, memory handshake,
// flush/perf controls and the stall/bubble/flush/counter outputs of
// pipe_stall_ctrl.
//   master : pipeline side (drives hazard/handshake inputs, observes controls)
//   slave  : the stall controller
interface pipe_stall_ctrl_if #(
  parameter int ISSUE_W = 2,
  parameter int PERF_W  = 32
);
  logic [ISSUE_W-1:0]   de_valid;
  logic [5*ISSUE_W-1:0] de_rs;
  logic [5*ISSUE_W-1:0] de_rt;
  logic [ISSUE_W-1:0]   ex_valid;
  logic [2*ISSUE_W-1:0] ex_mem_type;
  logic [5*ISSUE_W-1:0] ex_rt;
  logic [2*ISSUE_W-1:0] id_ex_mem_type;
  logic                 if_stall_i;
  logic                 ex_stall_i;
  logic                 mem_stall_i;
  logic                 mem_req;
  logic                 data_ok;
  logic                 flush;
  logic                 perf_clr;

  logic                 if_id_stall_o;
  logic                 id_ex_stall_o;
  logic                 ex_mem_stall_o;
  logic                 id_ex_bubble_o;
  logic                 flush_o;
  logic [2:0]           out_cnt_o;
  logic [PERF_W-1:0]    stall_cnt_o;
  logic [PERF_W-1:0]    lu_cnt_o;

  modport master (
    output de_valid, de_rs, de_rt, ex_valid, ex_mem_type, ex_rt,
           id_ex_mem_type, if_stall_i, ex_stall_i, mem_stall_i,
           mem_req, data_ok, flush, perf_clr,
    input  if_id_stall_o, id_ex_stall_o, ex_mem_stall_o, id_ex_bubble_o,
           flush_o, out_cnt_o, stall_cnt_o, lu_cnt_o
  );

  modport slave (
    input  de_valid, de_rs, de_rt, ex_valid, ex_mem_type, ex_rt,
           id_ex_mem_type, if_stall_i, ex_stall_i, mem_stall_i,
           mem_req, data_ok, flush, perf_clr,
    output if_id_stall_o, id_ex_stall_o, ex_mem_stall_o, id_ex_bubble_o,
           flush_o, out_cnt_o, stall_cnt_o, lu_cnt_o
  );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Hazard and stall controller for the N-issue pipeline.
// Detects load-use hazards across ISSUE_W lanes (inserting LU_BUBBLES stall
// cycles), optional store->load ordering stalls, tracks outstanding data
// requests (capped at MAX_OUT), defers flushes across fetch stalls and keeps
// saturating stall / load-use performance counters.
// Ports:
//   clk  - clock
//   rst  - asynchronous active-low reset
//   bus  - pipe_stall_ctrl_if.slave: hazard inputs, memory handshake,
//          flush/perf controls; stall, bubble, flush and counter outputs
module pipe_stall_ctrl #(
  parameter int         ISSUE_W       = 2,
  parameter int         LU_BUBBLES    = 1,
  parameter int         STORE_LOAD_EN = 1,
  parameter int         MAX_OUT       = 2,
  parameter int         PERF_W        = 32,
  parameter logic [1:0] MEM_LOAD      = 2'b01,
  parameter logic [1:0] MEM_STOR      = 2'b10
) (
  input logic               clk,
  input logic               rst,
  pipe_stall_ctrl_if.slave  bus
);

  typedef enum logic {FL_IDLE, FL_PEND} fl_state_e;

  fl_state_e         fl_q, fl_d;
  logic [1:0]        lu_cnt_q;
  logic [2:0]        out_cnt_q;
  logic [PERF_W-1:0] stall_cnt_q;
  logic [PERF_W-1:0] lu_evt_q;

  logic frozen, lu_hit, lu_stall, sl_stall, req_full, lu_load;
  logic ex_store, idex_load, flush_fire, out_inc, out_dec;

  // Hazard detection across all lane pairs
  always_comb begin
    lu_hit    = 1'b0;
    ex_store  = 1'b0;
    idex_load = 1'b0;
    for (int unsigned j = 0; j < ISSUE_W; j++) begin
      if (bus.ex_valid[j] && bus.ex_mem_type[2*j +: 2] == MEM_STOR)
        ex_store = 1'b1;
      if (bus.id_ex_mem_type[2*j +: 2] == MEM_LOAD)
        idex_load = 1'b1;
      for (int unsigned i = 0; i < ISSUE_W; i++) begin
        if (bus.ex_valid[j] && bus.ex_mem_type[2*j +: 2] == MEM_LOAD &&
            bus.ex_rt[5*j +: 5] != '0 && bus.de_valid[i] &&
            (bus.ex_rt[5*j +: 5] == bus.de_rs[5*i +: 5] ||
             bus.ex_rt[5*j +: 5] == bus.de_rt[5*i +: 5]))
          lu_hit = 1'b1;
      end
    end
  end

  always_comb begin
    frozen     = bus.if_stall_i | bus.mem_stall_i;
    lu_stall   = lu_hit | (lu_cnt_q != '0);
    sl_stall   = (STORE_LOAD_EN != 0) & ex_store & idex_load;
    req_full   = bus.mem_req & (out_cnt_q == 3'(MAX_OUT)) & ~bus.data_ok;
    flush_fire = (bus.flush | (fl_q == FL_PEND)) & ~bus.if_stall_i;
    lu_load    = lu_hit & (lu_cnt_q == '0) & ~frozen & ~flush_fire;
    // A request arriving at the cap is blocked, so it is never counted
    out_inc    = bus.mem_req & ~bus.data_ok & (out_cnt_q != 3'(MAX_OUT));
    out_dec    = bus.data_ok & ~bus.mem_req & (out_cnt_q != '0);
  end

  // Flush deferral: two states, pending held until fetch stall drops
  always_comb begin
    fl_d = fl_q;
    unique case (fl_q)
      FL_IDLE: if (bus.flush && bus.if_stall_i) fl_d = FL_PEND;
      FL_PEND: if (!bus.if_stall_i) fl_d = FL_IDLE;
      default: fl_d = FL_IDLE;
    endcase
  end

  always_comb begin
    bus.if_id_stall_o  = bus.ex_stall_i | lu_stall | sl_stall | frozen | req_full;
    bus.id_ex_stall_o  = frozen | req_full;
    bus.id_ex_bubble_o = (lu_stall | sl_stall) & ~(frozen | req_full) & ~bus.ex_stall_i;
    bus.flush_o        = flush_fire;
    if (bus.flush || fl_q == FL_PEND)
      bus.ex_mem_stall_o = bus.if_stall_i;
    else
      bus.ex_mem_stall_o = bus.mem_stall_i & ~bus.data_ok;
    bus.out_cnt_o      = out_cnt_q;
    bus.stall_cnt_o    = stall_cnt_q;
    bus.lu_cnt_o       = lu_evt_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fl_q        <= FL_IDLE;
      lu_cnt_q    <= '0;
      out_cnt_q   <= '0;
      stall_cnt_q <= '0;
      lu_evt_q    <= '0;
    end else begin
      fl_q <= fl_d;

      if (flush_fire)
        lu_cnt_q <= '0;
      else if (lu_load)
        lu_cnt_q <= 2'(LU_BUBBLES - 1);
      else if (lu_cnt_q != '0 && !frozen)
        lu_cnt_q <= lu_cnt_q - 2'd1;

      if (out_inc)
        out_cnt_q <= out_cnt_q + 3'd1;
      else if (out_dec)
        out_cnt_q <= out_cnt_q - 3'd1;

      if (bus.perf_clr)
        stall_cnt_q <= '0;
      else if (bus.if_id_stall_o && stall_cnt_q != '1)
        stall_cnt_q <= stall_cnt_q + 1'b1;

      if (bus.perf_clr)
        lu_evt_q <= '0;
      else if (lu_load && lu_evt_q != '1)
        lu_evt_q <= lu_evt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
module tb_pipe_stall_ctrl;
  localparam logic [1:0] LD = 2'b01;
  localparam logic [1:0] ST = 2'b10;
  localparam int S_IFID = 0, S_IDEX = 1, S_EXMEM = 2, S_BUB = 3,
                 S_FL = 4, S_OUT = 5, S_SC = 6, S_LU = 7;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] de_valid, ex_valid;
  logic [9:0] de_rs, de_rt, ex_rt;
  logic [3:0] ex_mem_type, id_ex_mem_type;
  logic if_stall_i, ex_stall_i, mem_stall_i, mem_req, data_ok, flush, perf_clr;

  pipe_stall_ctrl_if #(.ISSUE_W(2), .PERF_W(4)) ifa ();
  pipe_stall_ctrl_if #(.ISSUE_W(2), .PERF_W(4)) ifb ();

  assign ifa.de_valid = de_valid;             assign ifb.de_valid = de_valid;
  assign ifa.de_rs = de_rs;                   assign ifb.de_rs = de_rs;
  assign ifa.de_rt = de_rt;                   assign ifb.de_rt = de_rt;
  assign ifa.ex_valid = ex_valid;             assign ifb.ex_valid = ex_valid;
  assign ifa.ex_mem_type = ex_mem_type;       assign ifb.ex_mem_type = ex_mem_type;
  assign ifa.ex_rt = ex_rt;                   assign ifb.ex_rt = ex_rt;
  assign ifa.id_ex_mem_type = id_ex_mem_type; assign ifb.id_ex_mem_type = id_ex_mem_type;
  assign ifa.if_stall_i = if_stall_i;         assign ifb.if_stall_i = if_stall_i;
  assign ifa.ex_stall_i = ex_stall_i;         assign ifb.ex_stall_i = ex_stall_i;
  assign ifa.mem_stall_i = mem_stall_i;       assign ifb.mem_stall_i = mem_stall_i;
  assign ifa.mem_req = mem_req;               assign ifb.mem_req = mem_req;
  assign ifa.data_ok = data_ok;               assign ifb.data_ok = data_ok;
  assign ifa.flush = flush;                   assign ifb.flush = flush;
  assign ifa.perf_clr = perf_clr;             assign ifb.perf_clr = perf_clr;

  pipe_stall_ctrl #(.ISSUE_W(2), .LU_BUBBLES(2), .STORE_LOAD_EN(1), .MAX_OUT(2),
                    .PERF_W(4), .MEM_LOAD(LD), .MEM_STOR(ST))
    u_dut_a (.clk(clk), .rst(rst), .bus(ifa));

  pipe_stall_ctrl #(.ISSUE_W(2), .LU_BUBBLES(2), .STORE_LOAD_EN(0), .MAX_OUT(2),
                    .PERF_W(4), .MEM_LOAD(LD), .MEM_STOR(ST))
    u_dut_b (.clk(clk), .rst(rst), .bus(ifb));

  typedef struct {
    int          cyc;
    string       name;
    int          sel;
    bit          onb;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] act(input int sel, input bit onb);
    case (sel)
      S_IFID:  return onb ? 32'(ifb.if_id_stall_o)  : 32'(ifa.if_id_stall_o);
      S_IDEX:  return onb ? 32'(ifb.id_ex_stall_o)  : 32'(ifa.id_ex_stall_o);
      S_EXMEM: return onb ? 32'(ifb.ex_mem_stall_o) : 32'(ifa.ex_mem_stall_o);
      S_BUB:   return onb ? 32'(ifb.id_ex_bubble_o) : 32'(ifa.id_ex_bubble_o);
      S_FL:    return onb ? 32'(ifb.flush_o)        : 32'(ifa.flush_o);
      S_OUT:   return onb ? 32'(ifb.out_cnt_o)      : 32'(ifa.out_cnt_o);
      S_SC:    return onb ? 32'(ifb.stall_cnt_o)    : 32'(ifa.stall_cnt_o);
      S_LU:    return onb ? 32'(ifb.lu_cnt_o)       : 32'(ifa.lu_cnt_o);
      default: return 32'hdead_beef;
    endcase
  endfunction

  // Monitor: pops every expectation queued for the current cycle
  initial begin
    exp_t        e;
    logic [31:0] a;
    forever begin
      @(negedge clk);
      while (sb.size() != 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        n_chk++;
        if (e.cyc < cyc) begin
          n_fail++;
          $display("FAIL %s: check for cycle %0d missed (now %0d)", e.name, e.cyc, cyc);
        end else begin
          a = act(e.sel, e.onb);
          if (a !== e.exp) begin
            n_fail++;
            $display("FAIL %s (dut_%s, cycle %0d): got %0d expected %0d",
                     e.name, e.onb ? "b" : "a", cyc, a, e.exp);
          end
        end
      end
    end
  end

  task automatic ex(input string n, input int sel, input logic [31:0] v, input bit onb = 1'b0);
    exp_t e;
    e.cyc = cyc; e.name = n; e.sel = sel; e.onb = onb; e.exp = v;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    de_valid = '0; de_rs = '0; de_rt = '0; ex_valid = '0; ex_mem_type = '0;
    ex_rt = '0; id_ex_mem_type = '0; if_stall_i = 1'b0; ex_stall_i = 1'b0;
    mem_stall_i = 1'b0; mem_req = 1'b0; data_ok = 1'b0; flush = 1'b0; perf_clr = 1'b0;
  endtask

  // EX lane1 load to r8, decode lane0 reads r8 as rs
  task automatic hazard();
    idle();
    ex_valid = 2'b10; ex_mem_type = {LD, 2'b00}; ex_rt = {5'd8, 5'd0};
    de_valid = 2'b01; de_rs = {5'd0, 5'd8};
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    rst = 1'b0;
    tick(); tick();
    ex("rst_out", S_OUT, 0);   ex("rst_sc", S_SC, 0);    ex("rst_lu", S_LU, 0);
    ex("rst_ifid", S_IFID, 0); ex("rst_idex", S_IDEX, 0); ex("rst_exmem", S_EXMEM, 0);
    ex("rst_bub", S_BUB, 0);   ex("rst_fl", S_FL, 0);
    tick();
    rst = 1'b1;
    tick();

    // Load-use: two stall/bubble cycles, one event counted
    hazard();
    ex("lu0_ifid", S_IFID, 1); ex("lu0_bub", S_BUB, 1); ex("lu0_idex", S_IDEX, 0);
    ex("lu0_cnt", S_LU, 0);    ex("lu0_sc", S_SC, 0);
    tick(); idle();
    ex("lu1_ifid", S_IFID, 1); ex("lu1_bub", S_BUB, 1); ex("lu1_cnt", S_LU, 1);
    ex("lu1_sc", S_SC, 1);
    tick();
    ex("lu2_ifid", S_IFID, 0); ex("lu2_bub", S_BUB, 0); ex("lu2_sc", S_SC, 2);
    ex("lu2_cnt_b", S_LU, 1, 1'b1);
    tick();

    // r0 destination and invalid decode lane never hazard
    hazard(); ex_rt = '0; de_rs = '0;
    ex("r0_ifid", S_IFID, 0); ex("r0_bub", S_BUB, 0);
    tick();
    hazard(); de_valid = '0;
    ex("dv0_ifid", S_IFID, 0);
    tick(); idle();
    ex("nohz_cnt", S_LU, 1);
    tick();

    // rt match on decode lane1
    hazard(); de_valid = 2'b10; de_rs = '0; de_rt = {5'd8, 5'd0};
    ex("rt_ifid", S_IFID, 1); ex("rt_bub", S_BUB, 1);
    tick(); idle();
    ex("rt1_ifid", S_IFID, 1); ex("rt1_cnt", S_LU, 2); ex("rt1_sc", S_SC, 3);
    tick();

    // Store in EX ahead of load in ID/EX
    idle(); ex_valid = 2'b01; ex_mem_type = {2'b00, ST}; id_ex_mem_type = {LD, 2'b00};
    ex("sl_ifid_a", S_IFID, 1); ex("sl_bub_a", S_BUB, 1); ex("sl_sc_a", S_SC, 4);
    ex("sl_ifid_b", S_IFID, 0, 1'b1); ex("sl_bub_b", S_BUB, 0, 1'b1); ex("sl_sc_b", S_SC, 4, 1'b1);
    tick(); idle();
    ex("sl1_sc_a", S_SC, 5); ex("sl1_sc_b", S_SC, 4, 1'b1);
    tick();

    // Hazard while memory-frozen: no bubble, no count
    hazard(); mem_stall_i = 1'b1;
    ex("frz_ifid", S_IFID, 1); ex("frz_idex", S_IDEX, 1); ex("frz_bub", S_BUB, 0);
    ex("frz_exmem", S_EXMEM, 1);
    tick(); idle();
    ex("frz1_ifid", S_IFID, 0); ex("frz1_cnt", S_LU, 2);
    tick();

    // Outstanding requests, cap at 2
    mem_req = 1'b1;
    ex("req0_out", S_OUT, 0); ex("req0_idex", S_IDEX, 0);
    tick();
    ex("req1_out", S_OUT, 1); ex("req1_idex", S_IDEX, 0);
    tick();
    ex("req2_out", S_OUT, 2); ex("req2_idex", S_IDEX, 1); ex("req2_ifid", S_IFID, 1);
    tick();
    data_ok = 1'b1;
    ex("req3_out", S_OUT, 2); ex("req3_idex", S_IDEX, 0); ex("req3_ifid", S_IFID, 0);
    tick();
    mem_req = 1'b0;
    ex("ok0_out", S_OUT, 2);
    tick();
    ex("ok1_out", S_OUT, 1);
    tick();
    ex("ok2_out", S_OUT, 0);
    tick();
    mem_stall_i = 1'b1;
    ex("ok3_out", S_OUT, 0); ex("okstl_exmem", S_EXMEM, 0); ex("okstl_idex", S_IDEX, 1);
    tick(); idle();
    ex("ok4_out", S_OUT, 0);
    tick();

    // Flush deferred across a 3-cycle fetch stall, merged second flush
    flush = 1'b1; if_stall_i = 1'b1;
    ex("fd0_fl", S_FL, 0); ex("fd0_exmem", S_EXMEM, 1);
    tick(); flush = 1'b0;
    ex("fd1_fl", S_FL, 0); ex("fd1_exmem", S_EXMEM, 1);
    tick(); flush = 1'b1;
    ex("fd2_fl", S_FL, 0);
    tick(); idle();
    ex("fd3_fl", S_FL, 1); ex("fd3_exmem", S_EXMEM, 0);
    tick();
    ex("fd4_fl", S_FL, 0);
    tick();
    flush = 1'b1;
    ex("fi_fl", S_FL, 1);
    tick(); idle();
    ex("fi1_fl", S_FL, 0);
    tick();

    // Flush in the hazard cycle suppresses the bubble count
    hazard(); flush = 1'b1;
    ex("fh_fl", S_FL, 1); ex("fh_ifid", S_IFID, 1);
    tick(); idle();
    ex("fh1_ifid", S_IFID, 0); ex("fh1_cnt", S_LU, 2);
    tick();

    // Reset in the middle of a countdown with a pending flush
    hazard(); mem_req = 1'b1;
    tick(); idle(); flush = 1'b1; if_stall_i = 1'b1;
    ex("pr_ifid", S_IFID, 1); ex("pr_out", S_OUT, 1); ex("pr_cnt", S_LU, 3); ex("pr_fl", S_FL, 0);
    tick(); flush = 1'b0;
    ex("pr1_exmem", S_EXMEM, 1);
    tick(); idle();
    rst = 1'b0;
    #1;
    ex("ar_ifid", S_IFID, 0); ex("ar_fl", S_FL, 0); ex("ar_out", S_OUT, 0);
    ex("ar_sc", S_SC, 0);     ex("ar_cnt", S_LU, 0); ex("ar_bub", S_BUB, 0);
    tick();
    rst = 1'b1;
    tick();
    ex("post_fl", S_FL, 0); ex("post_ifid", S_IFID, 0);
    tick();

    // Saturate stall counter, then clear with priority over increment
    ex_stall_i = 1'b1;
    repeat (20) tick();
    ex("sat_sc", S_SC, 15); ex("sat_bub", S_BUB, 0);
    perf_clr = 1'b1;
    tick(); perf_clr = 1'b0;
    ex("clr_sc", S_SC, 0);
    tick(); idle();
    ex("clr1_sc", S_SC, 1);
    tick();

    tick(); tick();
    if (sb.size() != 0) begin
      n_chk += sb.size();
      n_fail += sb.size();
      $display("FAIL scoreboard: %0d expectations never checked", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
